// File: rtl/producao_bcd.sv
// producao_bcd: bottle-sealing counter with BCD cork stock, BCD dozen count and a
// scanned 4-digit display index.
module producao_bcd #(
    parameter int DIV_SCAN       = 50000,
    parameter int RECARGA        = 20,
    parameter int GARRAFAS_DUZIA = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ligado,
    input  logic       garrafa_vedada,
    input  logic       repor_rolhas,
    output logic [3:0] duzias_dezenas,
    output logic [3:0] duzias_unidades,
    output logic [3:0] rolhas_dezenas,
    output logic [3:0] rolhas_unidades,
    output logic [1:0] contador,
    output logic       sem_rolhas,
    output logic [1:0] estado
);
    localparam logic [1:0] PARADO   = 2'b00;
    localparam logic [1:0] OPERANDO = 2'b01;
    localparam logic [1:0] FALTA    = 2'b10;
    localparam int PW = (DIV_SCAN > 2) ? $clog2(DIV_SCAN) : 1;

    logic          armado_q, garrafa_q, repor_q, sem_q, sem_d;
    logic [3:0]    dz_dez_q, dz_dez_d, dz_uni_q, dz_uni_d;
    logic [3:0]    rl_dez_q, rl_dez_d, rl_uni_q, rl_uni_d;
    logic [3:0]    garrafas_q, garrafas_d;
    logic [1:0]    estado_q, estado_d, contador_q, contador_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sel_ev, rep_ev, aceita, virou, cheio, inc, fim;
    logic [6:0]    stock, recarregado, stock_d;
    logic [7:0]    soma;

    // armado_q masks the first edge after reset so an input already high is not an event
    always_comb begin
        sel_ev      = armado_q & garrafa_vedada & ~garrafa_q;
        rep_ev      = armado_q & repor_rolhas & ~repor_q;
        aceita      = sel_ev & ((estado_q == OPERANDO) | ((estado_q == FALTA) & rep_ev));
        stock       = 7'(rl_dez_q) * 7'd10 + 7'(rl_uni_q);
        soma        = 8'(stock) + 8'(RECARGA);
        recarregado = !rep_ev ? stock : (soma > 8'd99) ? 7'd99 : soma[6:0];
        stock_d     = (aceita && recarregado != 7'd0) ? recarregado - 7'd1 : recarregado;
        rl_dez_d    = 4'(stock_d / 7'd10);
        rl_uni_d    = 4'(stock_d % 7'd10);
        sem_d       = (stock_d == 7'd0);
        virou       = aceita && (garrafas_q == 4'(GARRAFAS_DUZIA - 1));
        garrafas_d  = !aceita ? garrafas_q : virou ? 4'd0 : garrafas_q + 4'd1;
        cheio       = (dz_dez_q == 4'd9) && (dz_uni_q == 4'd9);
        inc         = virou && !cheio;
        dz_uni_d    = !inc ? dz_uni_q : (dz_uni_q == 4'd9) ? 4'd0 : dz_uni_q + 4'd1;
        dz_dez_d    = (inc && dz_uni_q == 4'd9) ? dz_dez_q + 4'd1 : dz_dez_q;
        estado_d    = !ligado ? PARADO : (stock_d != 7'd0) ? OPERANDO : FALTA;
        fim         = (presc_q == PW'(DIV_SCAN - 1));
        presc_d     = fim ? '0 : presc_q + PW'(1);
        contador_d  = contador_q + 2'(fim);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armado_q   <= 1'b0;
            garrafa_q  <= 1'b0;
            repor_q    <= 1'b0;
            dz_dez_q   <= '0;
            dz_uni_q   <= '0;
            rl_dez_q   <= '0;
            rl_uni_q   <= '0;
            garrafas_q <= '0;
            estado_q   <= PARADO;
            sem_q      <= 1'b1;
            presc_q    <= '0;
            contador_q <= '0;
        end else begin
            armado_q   <= 1'b1;
            garrafa_q  <= garrafa_vedada;
            repor_q    <= repor_rolhas;
            dz_dez_q   <= dz_dez_d;
            dz_uni_q   <= dz_uni_d;
            rl_dez_q   <= rl_dez_d;
            rl_uni_q   <= rl_uni_d;
            garrafas_q <= garrafas_d;
            estado_q   <= estado_d;
            sem_q      <= sem_d;
            presc_q    <= presc_d;
            contador_q <= contador_d;
        end
    end

    assign duzias_dezenas  = dz_dez_q;
    assign duzias_unidades = dz_uni_q;
    assign rolhas_dezenas  = rl_dez_q;
    assign rolhas_unidades = rl_uni_q;
    assign contador        = contador_q;
    assign sem_rolhas      = sem_q;
    assign estado          = estado_q;
endmodule

// File: tb/tb_producao_bcd.sv
// tb_producao_bcd: integer-level reference model of the sealing counter, checked every cycle,
// plus directed scenarios with hand-computed literal expectations and a random phase.
module tb_producao_bcd;
    localparam int DIV = 4;
    localparam int REC = 20;

    logic       clk, reset, ligado, g, r;
    logic [3:0] dz_dez, dz_uni, rl_dez, rl_uni;
    logic [1:0] contador, estado;
    logic       sem_rolhas;
    int         tests = 0, fails = 0;
    bit         cmp_en = 0;

    producao_bcd #(.DIV_SCAN(DIV), .RECARGA(REC), .GARRAFAS_DUZIA(12)) dut (
        .clk(clk), .reset(reset), .ligado(ligado), .garrafa_vedada(g), .repor_rolhas(r),
        .duzias_dezenas(dz_dez), .duzias_unidades(dz_uni),
        .rolhas_dezenas(rl_dez), .rolhas_unidades(rl_uni),
        .contador(contador), .sem_rolhas(sem_rolhas), .estado(estado)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  stock, dz, bot;
        logic [1:0]  st;
        logic [31:0] n;
        logic        pg, pr, armed;
    } m_t;
    m_t m;

    function automatic m_t mstep(input m_t c, input logic l, input logic gi, input logic ri);
        m_t o = c;
        logic ge, re, acc;
        int s;
        ge  = c.armed & gi & ~c.pg;
        re  = c.armed & ri & ~c.pr;
        acc = ge && (c.st == 1 || (c.st == 2 && re));
        s   = int'(c.stock);
        if (re) s = (s + REC > 99) ? 99 : s + REC;
        if (acc) begin
            s = s - 1;
            if (c.bot == 11) begin
                o.bot = 0;
                if (c.dz < 99) o.dz = c.dz + 1;
            end else o.bot = c.bot + 1;
        end
        o.stock = 8'(s);
        o.st    = !l ? 2'd0 : (s > 0) ? 2'd1 : 2'd2;
        o.pg    = gi;
        o.pr    = ri;
        o.armed = 1'b1;
        o.n     = c.n + 1;
        return o;
    endfunction

    always @(posedge clk or posedge reset)
        if (reset) m <= '0;
        else m <= mstep(m, ligado, g, r);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (cmp_en) begin
            check("m_dz_dez", int'(dz_dez), int'(m.dz) / 10);
            check("m_dz_uni", int'(dz_uni), int'(m.dz) % 10);
            check("m_rl_dez", int'(rl_dez), int'(m.stock) / 10);
            check("m_rl_uni", int'(rl_uni), int'(m.stock) % 10);
            check("m_sem", int'(sem_rolhas), int'(m.stock == 0));
            check("m_estado", int'(estado), int'(m.st));
            check("m_contador", int'(contador), int'((m.n / DIV) % 4));
        end

    task automatic drive(input logic l, input logic gi, input logic ri);
        @(negedge clk);
        #1 ligado = l; g = gi; r = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic gi, input logic ri);
        drive(1, gi, ri);
        drive(1, 0, 0);
    endtask

    task automatic stock_is(input string name, input int v);
        check({name, "_dez"}, int'(rl_dez), v / 10);
        check({name, "_uni"}, int'(rl_uni), v % 10);
    endtask

    task automatic rst_pulse;
        @(negedge clk);
        #3 reset = 1;
        @(negedge clk);
        #1 reset = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 0; ligado = 0; g = 0; r = 0;
        #1 reset = 1;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        #1;
        stock_is("rst_stock", 0);
        check("rst_sem", int'(sem_rolhas), 1);
        check("rst_estado", int'(estado), 0);
        check("rst_contador", int'(contador), 0);
        check("rst_dz", int'({dz_dez, dz_uni}), 0);
        reset = 0;

        drive(1, 0, 0);
        drive(1, 0, 1);
        stock_is("refill20", 20);
        check("refill20_estado", int'(estado), 1);
        check("refill20_sem", int'(sem_rolhas), 0);
        drive(1, 0, 0);

        repeat (12) pulse(1, 0);
        stock_is("seal12", 8);
        check("seal12_dz", int'({dz_dez, dz_uni}), 8'h01);
        repeat (8) pulse(1, 0);
        stock_is("seal20", 0);
        check("seal20_sem", int'(sem_rolhas), 1);
        check("seal20_estado", int'(estado), 2);
        pulse(1, 0);
        stock_is("seal21", 0);
        check("seal21_dz", int'({dz_dez, dz_uni}), 8'h01);
        check("seal21_estado", int'(estado), 2);

        drive(1, 1, 1);
        stock_is("both_falta", 19);
        check("both_falta_estado", int'(estado), 1);
        drive(1, 0, 0);

        repeat (4) pulse(0, 1);
        stock_is("sat99", 99);
        repeat (9) pulse(1, 0);
        stock_is("at90", 90);
        pulse(0, 1);
        stock_is("90_refill", 99);
        repeat (89) pulse(1, 0);
        stock_is("at10", 10);
        pulse(1, 0);
        stock_is("borrow09", 9);
        pulse(1, 0);
        stock_is("at08", 8);

        k = 0;
        while ((dz_dez != 4'd9 || dz_uni != 4'd9) && k < 1300) begin
            pulse(1, 1);
            k++;
        end
        check("dz_reach99", int'({dz_dez, dz_uni}), 8'h99);
        repeat (24) pulse(1, 1);
        check("dz_sat99", int'({dz_dez, dz_uni}), 8'h99);
        stock_is("steady98", 98);
        drive(0, 0, 0);
        drive(0, 1, 0);
        check("parado_estado", int'(estado), 0);
        stock_is("parado_seal", 98);
        check("parado_dz", int'({dz_dez, dz_uni}), 8'h99);

        drive(1, 0, 0);
        drive(1, 0, 1);
        @(negedge clk);
        #3 reset = 1;
        #1;
        check("async_rst_contador", int'(contador), 0);
        stock_is("async_rst_stock", 0);
        @(negedge clk);
        #1 reset = 0;
        repeat (3) drive(1, 1, 1);
        stock_is("held_high", 0);
        check("held_high_estado", int'(estado), 2);
        check("held_high_dz", int'({dz_dez, dz_uni}), 0);

        rst_pulse();
        repeat (4) drive(0, 0, 0);
        check("scan_1", int'(contador), 1);
        repeat (4) drive(0, 0, 0);
        check("scan_2", int'(contador), 2);
        repeat (4) drive(0, 0, 0);
        check("scan_3", int'(contador), 3);
        repeat (4) drive(0, 0, 0);
        check("scan_wrap", int'(contador), 0);
        repeat (6) drive(0, 0, 0);
        check("scan_mid", int'(contador), 1);
        @(negedge clk);
        #3 reset = 1;
        #1;
        check("scan_async_rst", int'(contador), 0);
        @(negedge clk);
        #1 reset = 0;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) rst_pulse();
            drive($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        #1 cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
